pll_lock_supervisor: RTL

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_sup_pkg.sv | 21 ++
 rtl/pll_lock_supervisor_sync.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

    // Width of the saturating lock-loss counter.
    localparam int unsigned LOSS_W = 8;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAULT
    } sup_state_t;

    // Counter width for a counter that runs 0..limit-1; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync.sv
// sync_2ff: generic two-flop synchroniser for a single asynchronous bit.
module sync_2ff (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input; cleared by reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset/lock sequencing with staggered domain reset release.
// Optional feature macro: PLL_SUP_LOSS_COUNTER_EN enables the lock-loss counter;
// without it loss_count is tied to zero.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = 3,
    parameter int unsigned RST_PULSE      = 16,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned STAGGER_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES = 125000,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              pll_locked,
    output logic                              pll_rst,
    output logic [NUM_DOMAINS-1:0]            domain_rst_n,
    output logic                              all_ready,
    output logic                              fault,
    output logic [$clog2(MAX_RETRIES+2)-1:0]  retry_count,
    output logic [LOSS_W-1:0]                 loss_count
);

    localparam int unsigned RST_W    = cnt_width(RST_PULSE);
    localparam int unsigned STABLE_W = cnt_width(STABLE_CYCLES);
    localparam int unsigned TO_W     = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned REL_W    = cnt_width((NUM_DOMAINS - 1) * STAGGER_CYCLES);
    localparam int unsigned RETRY_W  = $clog2(MAX_RETRIES + 2);

    localparam logic [RST_W-1:0]    RST_LAST    = RST_W'(RST_PULSE - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REL_W-1:0]    REL_LAST    = REL_W'((NUM_DOMAINS - 1) * STAGGER_CYCLES - 1);
    localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    sup_state_t           state, state_next;
    logic                 lock_s;
    logic [RST_W-1:0]     rst_cnt, rst_cnt_next;
    logic [STABLE_W-1:0]  stable_cnt, stable_cnt_next;
    logic [TO_W-1:0]      to_cnt, to_cnt_next;
    logic [REL_W-1:0]     rel_cnt, rel_cnt_next;
    logic [RETRY_W-1:0]   retry_next;
    logic [NUM_DOMAINS-1:0] domain_next;

    sync_2ff u_lock_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (pll_locked),
        .q      (lock_s)
    );

    // Next-state and counter logic for the supervisor FSM.
    always_comb begin
        state_next      = state;
        rst_cnt_next    = rst_cnt;
        stable_cnt_next = stable_cnt;
        to_cnt_next     = to_cnt;
        rel_cnt_next    = rel_cnt;
        retry_next      = retry_count;
        case (state)
            RESET_PLL: begin
                if (rst_cnt == RST_LAST) begin
                    state_next  = WAIT_LOCK;
                    to_cnt_next = '0;
                end else begin
                    rst_cnt_next = rst_cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_next      = STABLE;
                    stable_cnt_next = '0;
                end else if (to_cnt == TO_LAST) begin
                    retry_next   = retry_count + 1'b1;
                    state_next   = (retry_next > RETRY_MAX) ? FAULT : RESET_PLL;
                    rst_cnt_next = '0;
                end else begin
                    to_cnt_next = to_cnt + 1'b1;
                end
            end
            STABLE: begin
                // The attempt timeout keeps running here so a flapping lock cannot extend it.
                if (to_cnt != TO_LAST) begin
                    to_cnt_next = to_cnt + 1'b1;
                end
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end else if (stable_cnt == STABLE_LAST) begin
                    rel_cnt_next = '0;
                    if (NUM_DOMAINS > 1) begin
                        state_next = RELEASE;
                    end else begin
                        state_next = RUN;
                        retry_next = '0;
                    end
                end else begin
                    stable_cnt_next = stable_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_next   = RESET_PLL;
                    rst_cnt_next = '0;
                end else if (rel_cnt == REL_LAST) begin
                    state_next = RUN;
                    retry_next = '0;
                end else begin
                    rel_cnt_next = rel_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_next   = RESET_PLL;
                    rst_cnt_next = '0;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next   = RESET_PLL;
                rst_cnt_next = '0;
            end
        endcase
    end

    // Domain reset pattern for the upcoming state; domains only ever release in index order.
    always_comb begin
        domain_next = '0;
        if (state_next == RUN) begin
            domain_next = '1;
        end else if (state_next == RELEASE) begin
            for (int unsigned k = 0; k < NUM_DOMAINS - 1; k++) begin
                if (rel_cnt_next >= REL_W'(k * STAGGER_CYCLES)) begin
                    domain_next = domain_next | (NUM_DOMAINS'(1) << k);
                end
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= RESET_PLL;
            rst_cnt      <= '0;
            stable_cnt   <= '0;
            to_cnt       <= '0;
            rel_cnt      <= '0;
            retry_count  <= '0;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            all_ready    <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_next;
            rst_cnt      <= rst_cnt_next;
            stable_cnt   <= stable_cnt_next;
            to_cnt       <= to_cnt_next;
            rel_cnt      <= rel_cnt_next;
            retry_count  <= retry_next;
            pll_rst      <= (state_next == RESET_PLL) || (state_next == FAULT);
            domain_rst_n <= domain_next;
            all_ready    <= (state_next == RUN);
            fault        <= (state_next == FAULT);
        end
    end

`ifdef PLL_SUP_LOSS_COUNTER_EN
    logic lost;
    assign lost = ((state == RELEASE) || (state == RUN)) && !lock_s;

    // Saturating count of lock-loss events seen after release began.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            loss_count <= '0;
        end else if (lost && (loss_count != '1)) begin
            loss_count <= loss_count + 1'b1;
        end
    end
`else
    assign loss_count = '0;
`endif

endmodule
